// File: rtl/accelerator_pkg.sv
// Shared types and constants for the vector issue sequencer.
// Writeback delay-line entries carry the operand-cycle identity down to the register port.
package accelerator_pkg;

  localparam int VEC_LANES  = 4;
  localparam int VEC_MAX_VL = 16;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_RUN,
    SEQ_DRAIN
  } seq_state_t;

  // pend marks a real operand cycle; wr is set only when that cycle also writes vd.
  typedef struct packed {
    logic       pend;
    logic       wr;
    logic [1:0] cc;
    logic [1:0] etw;
  } wb_entry_t;

endpackage

// File: rtl/vseq_wb_delay.sv
// Fixed-depth shift register for the writeback path. It advances only while enabled
// and flags when the line will hold no operand entries after the next shift.
module vseq_wb_delay
  import accelerator_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic      clk,
  input  logic      clear,
  input  logic      enable,
  input  wb_entry_t din,
  output wb_entry_t head,
  output logic      empty_next
);

  wb_entry_t stage [DEPTH];

  always_ff @(posedge clk) begin
    if (clear) begin
      stage <= '{default: '0};
    end else if (enable) begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign head = stage[DEPTH-1];

  // Only entries behind the head matter: the head leaves on the next shift.
  always_comb begin
    empty_next = 1'b1;
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (stage[i].pend) empty_next = 1'b0;
    end
  end

endmodule

// File: rtl/vector_op_sequencer.sv
// Issue-side sequencer: splits one vector instruction into 4-lane operand cycles and
// replays them, WB_LATENCY cycles later, onto the vector register write port.
//
// state     | meaning
// SEQ_IDLE  | ready for a new instruction
// SEQ_RUN   | issuing operand cycles 0..N-1
// SEQ_DRAIN | waiting for the writeback line to empty; done_o on the last slot
module vector_op_sequencer
  import accelerator_pkg::*;
#(
  parameter int LANES      = VEC_LANES,
  parameter int MAX_VL     = VEC_MAX_VL,
  parameter int WB_LATENCY = 1
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       issue_valid_i,
  output logic       issue_ready_o,
  input  logic [4:0] vl_i,
  input  logic       vd_write_i,
  input  logic       stall_i,
  output logic       operand_valid_o,
  output logic [1:0] cycle_count_o,
  output logic [1:0] elements_to_write_o,
  output logic       vec_reg_write_o,
  output logic [1:0] wb_cycle_count_o,
  output logic [1:0] wb_elements_o,
  output logic       busy_o,
  output logic       done_o
);

  seq_state_t state;
  logic [1:0] counter;
  logic [4:0] vle;
  logic       vd_write;

  logic [4:0] vl_clamped;
  logic [4:0] remaining;
  logic [1:0] etw;
  logic [1:0] last_idx;
  logic       running;
  logic       empty_next;
  wb_entry_t  push_entry;
  wb_entry_t  head;

  assign vl_clamped = (vl_i > 5'(MAX_VL)) ? 5'(MAX_VL) : vl_i;
  assign remaining  = vle - {1'b0, counter, 2'b00};
  assign etw        = (remaining >= 5'(LANES)) ? 2'(LANES - 1) : 2'(remaining - 5'd1);
  assign last_idx   = 2'((vle - 5'd1) >> 2);
  assign running    = (state == SEQ_RUN);

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state    <= SEQ_IDLE;
      counter  <= '0;
      vle      <= '0;
      vd_write <= 1'b0;
    end else begin
      case (state)
        SEQ_IDLE: begin
          if (issue_valid_i) begin
            vle      <= vl_clamped;
            vd_write <= vd_write_i;
            counter  <= '0;
            state    <= (vl_clamped == 5'd0) ? SEQ_DRAIN : SEQ_RUN;
          end
        end
        SEQ_RUN: begin
          if (!stall_i) begin
            if (counter == last_idx) state <= SEQ_DRAIN;
            else                     counter <= counter + 2'd1;
          end
        end
        SEQ_DRAIN: begin
          if (!stall_i && empty_next) begin
            state   <= SEQ_IDLE;
            counter <= '0;
          end
        end
        default: state <= SEQ_IDLE;
      endcase
    end
  end

  always_comb begin
    push_entry      = '0;
    push_entry.pend = running;
    push_entry.wr   = running && vd_write;
    push_entry.cc   = running ? counter : 2'd0;
    push_entry.etw  = running ? etw : 2'd0;
  end

  vseq_wb_delay #(
    .DEPTH(WB_LATENCY)
  ) u_wb_delay (
    .clk       (clk),
    .clear     (!n_reset),
    .enable    (!stall_i),
    .din       (push_entry),
    .head      (head),
    .empty_next(empty_next)
  );

  assign issue_ready_o       = (state == SEQ_IDLE);
  assign busy_o              = (state != SEQ_IDLE);
  assign operand_valid_o     = running && !stall_i;
  assign cycle_count_o       = running ? counter : 2'd0;
  assign elements_to_write_o = running ? etw : 2'd0;
  assign vec_reg_write_o     = head.pend && head.wr && !stall_i;
  assign wb_cycle_count_o    = head.cc;
  assign wb_elements_o       = head.etw;
  // Retire when the final slot leaves the line, whether or not it writes.
  assign done_o              = (state == SEQ_DRAIN) && !stall_i && empty_next;

endmodule

// File: tb/tb_vector_op_sequencer.sv
// Scoreboard bench: two sequencers (WB_LATENCY 1 and 2) see identical directed stimulus;
// expected operand/write/done events are queued at issue and popped by a monitor.
module tb_vector_op_sequencer;

  typedef struct {
    int cyc;
    int cc;
    int etw;
  } ev_t;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       issue_valid = 1'b0;
  logic [4:0] vl_i = '0;
  logic       vd_write_i = 1'b0;
  logic       stall_i = 1'b0;

  logic [1:0] rdy, op_v, wr, dn, bsy;
  logic [1:0] cc [2];
  logic [1:0] etw [2];
  logic [1:0] wcc [2];
  logic [1:0] wel [2];

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  ev_t opq [2][$];
  ev_t wq  [2][$];
  int  dq  [2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vector_op_sequencer #(.WB_LATENCY(1)) dut_l1 (
    .clk(clk), .n_reset(n_reset), .issue_valid_i(issue_valid), .issue_ready_o(rdy[0]),
    .vl_i(vl_i), .vd_write_i(vd_write_i), .stall_i(stall_i),
    .operand_valid_o(op_v[0]), .cycle_count_o(cc[0]), .elements_to_write_o(etw[0]),
    .vec_reg_write_o(wr[0]), .wb_cycle_count_o(wcc[0]), .wb_elements_o(wel[0]),
    .busy_o(bsy[0]), .done_o(dn[0]));

  vector_op_sequencer #(.WB_LATENCY(2)) dut_l2 (
    .clk(clk), .n_reset(n_reset), .issue_valid_i(issue_valid), .issue_ready_o(rdy[1]),
    .vl_i(vl_i), .vd_write_i(vd_write_i), .stall_i(stall_i),
    .operand_valid_o(op_v[1]), .cycle_count_o(cc[1]), .elements_to_write_o(etw[1]),
    .vec_reg_write_o(wr[1]), .wb_cycle_count_o(wcc[1]), .wb_elements_o(wel[1]),
    .busy_o(bsy[1]), .done_o(dn[1]));

  // Monitor: every presented event must match the head of its queue.
  always @(negedge clk) begin : monitor
    ev_t e;
    int  dc;
    for (int d = 0; d < 2; d++) begin
      if (op_v[d] === 1'b1) begin
        checks++;
        if (opq[d].size() == 0) begin
          errors++;
          $display("FAIL operand dut%0d: unexpected operand at cyc=%0d cc=%0d", d, cyc, cc[d]);
        end else begin
          e = opq[d].pop_front();
          if (e.cyc != cyc || e.cc != int'(cc[d]) || e.etw != int'(etw[d])) begin
            errors++;
            $display("FAIL operand dut%0d: got cyc=%0d cc=%0d etw=%0d, want cyc=%0d cc=%0d etw=%0d",
                     d, cyc, cc[d], etw[d], e.cyc, e.cc, e.etw);
          end
        end
      end
      if (wr[d] === 1'b1) begin
        checks++;
        if (wq[d].size() == 0) begin
          errors++;
          $display("FAIL write dut%0d: unexpected write at cyc=%0d wbcc=%0d", d, cyc, wcc[d]);
        end else begin
          e = wq[d].pop_front();
          if (e.cyc != cyc || e.cc != int'(wcc[d]) || e.etw != int'(wel[d])) begin
            errors++;
            $display("FAIL write dut%0d: got cyc=%0d wbcc=%0d wbel=%0d, want cyc=%0d wbcc=%0d wbel=%0d",
                     d, cyc, wcc[d], wel[d], e.cyc, e.cc, e.etw);
          end
        end
      end
      if (dn[d] === 1'b1) begin
        checks++;
        if (dq[d].size() == 0) begin
          errors++;
          $display("FAIL done dut%0d: unexpected done at cyc=%0d", d, cyc);
        end else begin
          dc = dq[d].pop_front();
          if (dc != cyc) begin
            errors++;
            $display("FAIL done dut%0d: got cyc=%0d, want cyc=%0d", d, cyc, dc);
          end
        end
      end
    end
  end

  function automatic int shf(input int c, input int s0, input int sl);
    return (sl > 0 && c >= s0) ? c + sl : c;
  endfunction

  // Reference timing: nominal schedule, shifted by any stall window, truncated at an abort.
  task automatic push_exp(input int d, input int lat, input int t, input int vl, input bit vdw,
                          input int s0, input int sl, input int ab_cyc, output int rdy_cyc);
    int  vle, n, c, rem;
    ev_t e;
    vle = (vl > 16) ? 16 : vl;
    n   = (vle + 3) / 4;
    for (int j = 0; j < n; j++) begin
      rem   = vle - 4 * j;
      e.cc  = j;
      e.etw = (rem >= 4) ? 3 : rem - 1;
      e.cyc = shf(t + 1 + j, s0, sl);
      if (e.cyc <= ab_cyc) opq[d].push_back(e);
      if (vdw) begin
        e.cyc = shf(t + 1 + j + lat, s0, sl);
        if (e.cyc <= ab_cyc) wq[d].push_back(e);
      end
    end
    c = (vle == 0) ? shf(t + 1, s0, sl) : shf(t + n + lat, s0, sl);
    if (c <= ab_cyc) begin
      dq[d].push_back(c);
      rdy_cyc = c + 1;
    end else begin
      rdy_cyc = ab_cyc + 1;
    end
  endtask

  task automatic run_txn(input string nm, input int vl, input bit vdw,
                         input int st_off, input int st_len, input int ab_off);
    int t, c, ab_cyc;
    int exp_r [2];
    int seen [2];
    @(posedge clk); #1;
    t           = cyc;
    issue_valid = 1'b1;
    vl_i        = 5'(vl);
    vd_write_i  = vdw;
    ab_cyc      = (ab_off > 0) ? t + ab_off : 32'h3fff_ffff;
    push_exp(0, 1, t, vl, vdw, t + st_off, st_len, ab_cyc, exp_r[0]);
    push_exp(1, 2, t, vl, vdw, t + st_off, st_len, ab_cyc, exp_r[1]);
    seen[0] = -1;
    seen[1] = -1;
    for (int k = 1; k <= 40 && (seen[0] < 0 || seen[1] < 0); k++) begin
      @(posedge clk); #1;
      c           = cyc;
      issue_valid = 1'b0;
      stall_i     = (st_len > 0 && c >= t + st_off && c < t + st_off + st_len);
      n_reset     = !(ab_off > 0 && c == t + ab_off);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (seen[d] < 0 && rdy[d] === 1'b1) begin
          seen[d] = c;
          checks++;
          if (c != exp_r[d]) begin
            errors++;
            $display("FAIL %s ready dut%0d: ready at cyc=%0d, want cyc=%0d", nm, d, c, exp_r[d]);
          end
        end
        if (stall_i) begin
          checks++;
          if (op_v[d] !== 1'b0 || wr[d] !== 1'b0 || int'(cc[d]) != st_off - 1) begin
            errors++;
            $display("FAIL %s stall dut%0d: op_v=%b wr=%b cc=%0d, want 0 0 %0d",
                     nm, d, op_v[d], wr[d], cc[d], st_off - 1);
          end
        end
        if (ab_off > 0 && c == t + ab_off + 1) begin
          checks++;
          if (bsy[d] !== 1'b0 || rdy[d] !== 1'b1 || op_v[d] !== 1'b0 || wr[d] !== 1'b0 ||
              dn[d] !== 1'b0 || cc[d] !== 2'd0 || etw[d] !== 2'd0 || wcc[d] !== 2'd0 ||
              wel[d] !== 2'd0) begin
            errors++;
            $display("FAIL %s abort dut%0d: busy=%b ready=%b op=%b wr=%b done=%b cc=%0d etw=%0d wbcc=%0d wbel=%0d, want idle",
                     nm, d, bsy[d], rdy[d], op_v[d], wr[d], dn[d], cc[d], etw[d], wcc[d], wel[d]);
          end
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      if (seen[d] < 0) begin
        checks++;
        errors++;
        $display("FAIL %s timeout dut%0d: ready never returned, want cyc=%0d", nm, d, exp_r[d]);
      end
    end
    stall_i = 1'b0;
    n_reset = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (rdy[d] !== 1'b1 || bsy[d] !== 1'b0 || op_v[d] !== 1'b0 || wr[d] !== 1'b0 ||
          dn[d] !== 1'b0 || cc[d] !== 2'd0 || etw[d] !== 2'd0 || wcc[d] !== 2'd0 ||
          wel[d] !== 2'd0) begin
        errors++;
        $display("FAIL reset dut%0d: ready=%b busy=%b op=%b wr=%b done=%b, want 1 0 0 0 0",
                 d, rdy[d], bsy[d], op_v[d], wr[d], dn[d]);
      end
    end
    @(posedge clk); #1;
    n_reset = 1'b1;

    run_txn("vl7",       7, 1'b1, 0, 0, 0);
    run_txn("vl16",     16, 1'b1, 0, 0, 0);
    run_txn("vl0",       0, 1'b1, 0, 0, 0);
    run_txn("vl20",     20, 1'b1, 0, 0, 0);
    run_txn("vl9_stall", 9, 1'b1, 2, 2, 0);
    run_txn("vl5_nowr",  5, 1'b0, 0, 0, 0);
    run_txn("vl16_rst", 16, 1'b1, 0, 0, 3);
    run_txn("vl4",       4, 1'b1, 0, 0, 0);
    run_txn("vl1",       1, 1'b1, 0, 0, 0);
    run_txn("vl12",     12, 1'b1, 0, 0, 0);

    repeat (5) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (opq[d].size() != 0) begin
        errors++;
        $display("FAIL drain_operand dut%0d: %0d operand events missing, want 0", d, opq[d].size());
      end
      checks++;
      if (wq[d].size() != 0) begin
        errors++;
        $display("FAIL drain_write dut%0d: %0d write events missing, want 0", d, wq[d].size());
      end
      checks++;
      if (dq[d].size() != 0) begin
        errors++;
        $display("FAIL drain_done dut%0d: %0d done pulses missing, want 0", d, dq[d].size());
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
